// File: rtl/cpu_trace_pkg.sv
// Shared types and field layout for the CPU trace buffer.
// Benches import this to decode drained entries.
package cpu_trace_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  localparam logic [1:0] TRIG_IMM = 2'd0;
  localparam logic [1:0] TRIG_OPC = 2'd1;
  localparam logic [1:0] TRIG_PC  = 2'd2;
  localparam logic [1:0] TRIG_EXT = 2'd3;

  localparam int TR_DEPTH   = 16;
  localparam int TR_INSTR_W = 16;
  localparam int TR_PC_W    = 3;
  localparam int TR_STATE_W = 2;
  localparam int TR_CYCLE_W = 16;
  localparam int TR_POST    = 8;
  localparam int TR_OPC_W   = 4;

  // Entry layout, LSB first: instr, pc, state, cycle.
  localparam int INSTR_LSB  = 0;
  localparam int PC_LSB     = INSTR_LSB + TR_INSTR_W;
  localparam int STATE_LSB  = PC_LSB + TR_PC_W;
  localparam int CYCLE_LSB  = STATE_LSB + TR_STATE_W;
  localparam int TR_ENTRY_W = CYCLE_LSB + TR_CYCLE_W;

  function automatic bit is_pow2(int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/cpu_trace_buffer_ram.sv
// Trace storage: one synchronous write port and one registered read port.
// Only the read register is reset; the array itself is not.
module trace_ram
  import cpu_trace_pkg::*;
#(
  parameter int DEPTH = TR_DEPTH,
  parameter int W     = TR_ENTRY_W,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/cpu_trace_buffer.sv
// Circular execution-trace capture with programmable trigger
// and post-trigger depth, drained oldest-first over valid/ready.
module cpu_trace_buffer
  import cpu_trace_pkg::*;
#(
  parameter int DEPTH   = TR_DEPTH,
  parameter int INSTR_W = TR_INSTR_W,
  parameter int PC_W    = TR_PC_W,
  parameter int STATE_W = TR_STATE_W,
  parameter int CYCLE_W = TR_CYCLE_W,
  parameter int POST    = TR_POST,
  parameter int OPC_W   = TR_OPC_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               arm,
  input  logic [1:0]         trig_mode,
  input  logic [INSTR_W-1:0] trig_value,
  input  logic               trig_ext,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [STATE_W-1:0] state_in,
  input  logic [PC_W-1:0]    pc_in,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [CYCLE_W+STATE_W+PC_W+INSTR_W-1:0] rd_data,
  output logic               busy,
  output logic               triggered,
  output logic               wrapped
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int ENTRY_W = CYCLE_W + STATE_W + PC_W + INSTR_W;

  localparam logic [CW-1:0] FULL      = CW'(DEPTH);
  localparam logic [CW-1:0] ONE       = CW'(1);
  localparam logic [CW-1:0] POST_INIT = CW'(POST - 1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  if (!is_pow2(DEPTH) || DEPTH < 4) begin : g_bad_depth
    $error("DEPTH must be a power of 2 and >= 4");
  end
  if (POST < 1 || POST > DEPTH) begin : g_bad_post
    $error("POST must be in 1..DEPTH");
  end

  state_t state_q;
  state_t state_n;

  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      wr_ptr_n;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      count;
  logic [CW-1:0]      count_n;
  logic [CW-1:0]      rd_left;
  logic [CW-1:0]      post_left;
  logic [CYCLE_W-1:0] cycle;

  logic               hit;
  logic               wen;
  logic               ren;
  logic               hs;
  logic               start_drain;
  logic [ENTRY_W-1:0] wdata;

  // Only the low OPC_W / PC_W bits of trig_value take part in compares.
  logic unused_trig_bits;
  assign unused_trig_bits = ^trig_value;

  assign hs       = rd_valid && rd_ready;
  assign busy     = (state_q != IDLE);
  assign wr_ptr_n = wr_ptr + PTR_ONE;
  assign count_n  = (count == FULL) ? count : count + ONE;
  assign wdata    = {cycle, state_in, pc_in, instr_in};

  always_comb begin
    hit = 1'b0;
    unique case (trig_mode)
      TRIG_IMM: hit = 1'b1;
      TRIG_OPC: hit = (instr_in[INSTR_W-1 -: OPC_W]
                       == trig_value[OPC_W-1:0]);
      TRIG_PC:  hit = (pc_in == trig_value[PC_W-1:0]);
      TRIG_EXT: hit = trig_ext;
      default:  hit = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  always_comb begin
    state_n     = state_q;
    wen         = 1'b0;
    ren         = 1'b0;
    start_drain = 1'b0;
    if (arm) begin
      state_n = ARMED;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_n = IDLE;
        end
        ARMED: begin
          wen = 1'b1;
          if (hit) begin
            if (POST == 1) begin
              state_n     = DRAIN;
              start_drain = 1'b1;
            end else begin
              state_n = CAPTURE;
            end
          end
        end
        CAPTURE: begin
          wen = 1'b1;
          // post_left counts the writes still owed, this one included.
          if (post_left == ONE) begin
            state_n     = DRAIN;
            start_drain = 1'b1;
          end
        end
        DRAIN: begin
          ren = !rd_valid && (rd_left != '0);
          if ((hs && rd_left == ONE) || rd_left == '0) begin
            state_n = IDLE;
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rd_left   <= '0;
      post_left <= '0;
      cycle     <= '0;
      rd_valid  <= 1'b0;
      triggered <= 1'b0;
      wrapped   <= 1'b0;
    end else if (arm) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rd_left   <= '0;
      post_left <= '0;
      cycle     <= '0;
      rd_valid  <= 1'b0;
      triggered <= 1'b0;
      wrapped   <= 1'b0;
    end else begin
      if (wen) begin
        wr_ptr <= wr_ptr_n;
        count  <= count_n;
        if (cycle != '1) begin
          cycle <= cycle + CYCLE_W'(1);
        end
        if (count == FULL) begin
          wrapped <= 1'b1;
        end
      end
      if (state_q == ARMED && hit) begin
        triggered <= 1'b1;
        post_left <= POST_INIT;
      end
      if (state_q == CAPTURE) begin
        post_left <= post_left - ONE;
      end
      // Oldest entry sits at the next write slot once the ring is full.
      if (start_drain) begin
        rd_ptr  <= (count_n == FULL) ? wr_ptr_n : '0;
        rd_left <= count_n;
      end
      if (ren) begin
        rd_valid <= 1'b1;
      end
      if (hs) begin
        rd_valid <= 1'b0;
        rd_ptr   <= rd_ptr + PTR_ONE;
        rd_left  <= rd_left - ONE;
      end
    end
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wen),
    .waddr (wr_ptr),
    .wdata (wdata),
    .re    (ren),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Scoreboard bench for cpu_trace_buffer: directed captures,
// expected entries queued at issue, checked by a drain monitor.
module tb_cpu_trace_buffer;
  import cpu_trace_pkg::*;

  localparam int EW = TR_ENTRY_W;

  logic          clk = 1'b0;
  logic          rst;
  logic          arm;
  logic [1:0]    trig_mode;
  logic [15:0]   trig_value;
  logic          trig_ext;
  logic [15:0]   instr_in;
  logic [1:0]    state_in;
  logic [2:0]    pc_in;
  logic          rd_valid;
  logic          rd_ready;
  logic [EW-1:0] rd_data;
  logic          busy;
  logic          triggered;
  logic          wrapped;

  int n_tests = 0;
  int n_fail  = 0;
  int n_pop   = 0;
  logic [EW-1:0] exp_q [$];

  always #5 clk = ~clk;

  cpu_trace_buffer #(
    .DEPTH   (16),
    .INSTR_W (16),
    .PC_W    (3),
    .STATE_W (2),
    .CYCLE_W (16),
    .POST    (8),
    .OPC_W   (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .arm        (arm),
    .trig_mode  (trig_mode),
    .trig_value (trig_value),
    .trig_ext   (trig_ext),
    .instr_in   (instr_in),
    .state_in   (state_in),
    .pc_in      (pc_in),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .busy       (busy),
    .triggered  (triggered),
    .wrapped    (wrapped)
  );

  // Stimulus seen by the CPU at timestamp k after arm.
  function automatic logic [3:0] op_of(int k);
    if (k == 3 || k == 6) return 4'hA;
    return 4'(k % 8);
  endfunction

  function automatic logic [15:0] instr_of(int k);
    return {op_of(k), 12'(k * 7 + 3)};
  endfunction

  function automatic logic [2:0] pc_of(int k);
    if (k == 20 || k == 23) return 3'd5;
    return 3'(k % 5);
  endfunction

  function automatic logic [1:0] st_of(int k);
    return 2'(k % 4);
  endfunction

  function automatic logic [EW-1:0] entry_of(int c);
    return {16'(c), st_of(c), pc_of(c), instr_of(c)};
  endfunction

  task automatic check(string name, logic [63:0] act,
                       logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rd_valid) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_entry: got %0h, expected none",
                   rd_data);
        end else begin
          check("rd_data", 64'(rd_data), 64'(exp_q[0]));
        end
        if (rd_ready) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          n_pop++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    instr_in = 16'hF123;
    pc_in    = 3'd7;
    state_in = 2'd0;
    trig_ext = 1'b0;
  endtask

  task automatic drive(int k);
    instr_in = instr_of(k);
    pc_in    = pc_of(k);
    state_in = st_of(k);
  endtask

  task automatic do_arm(logic [1:0] mode, logic [15:0] tv);
    trig_mode  = mode;
    trig_value = tv;
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic capture(int last, int ext_at);
    for (int k = 0; k <= last; k++) begin
      drive(k);
      trig_ext = (k == ext_at);
      tick();
    end
    idle_inputs();
  endtask

  task automatic expect_range(int first, int last);
    for (int c = first; c <= last; c++) exp_q.push_back(entry_of(c));
  endtask

  task automatic wait_drain(string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 300) begin
      tick();
      n++;
    end
    check(name, 64'(n < 300), 64'(1));
  endtask

  task automatic wait_reads(string name, int base, int reads);
    int n;
    n = 0;
    while (!((n_pop - base) >= reads && rd_valid) && n < 300) begin
      tick();
      n++;
    end
    check(name, 64'(n < 300), 64'(1));
  endtask

  initial begin
    int base;
    rst        = 1'b1;
    arm        = 1'b0;
    rd_ready   = 1'b1;
    trig_mode  = TRIG_IMM;
    trig_value = 16'h0;
    idle_inputs();
    repeat (3) tick();
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_rd_valid", 64'(rd_valid), 64'(0));
    check("reset_rd_data", 64'(rd_data), 64'(0));
    check("reset_triggered", 64'(triggered), 64'(0));
    check("reset_wrapped", 64'(wrapped), 64'(0));
    rst = 1'b0;
    tick();

    // T1: async reset in the middle of a capture
    do_arm(TRIG_IMM, 16'h0);
    for (int k = 0; k < 4; k++) begin
      drive(k);
      tick();
    end
    @(negedge clk);
    check("t1_busy_before", 64'(busy), 64'(1));
    check("t1_trig_before", 64'(triggered), 64'(1));
    #2 rst = 1'b1;
    #1;
    check("t1_busy", 64'(busy), 64'(0));
    check("t1_rd_valid", 64'(rd_valid), 64'(0));
    check("t1_triggered", 64'(triggered), 64'(0));
    check("t1_wrapped", 64'(wrapped), 64'(0));
    idle_inputs();
    tick();
    rst = 1'b0;
    tick();

    // T2: immediate trigger, POST entries from cycle 0
    base = n_pop;
    expect_range(0, 7);
    do_arm(TRIG_IMM, 16'h0);
    capture(7, -1);
    wait_drain("t2_drain");
    check("t2_count", 64'(n_pop - base), 64'(8));
    check("t2_triggered", 64'(triggered), 64'(1));
    check("t2_wrapped", 64'(wrapped), 64'(0));

    // T3: pc trigger at cycle 20, ring has wrapped
    base = n_pop;
    expect_range(12, 27);
    do_arm(TRIG_PC, 16'hABC5);
    capture(27, -1);
    wait_drain("t3_drain");
    check("t3_count", 64'(n_pop - base), 64'(16));
    check("t3_wrapped", 64'(wrapped), 64'(1));
    check("t3_triggered", 64'(triggered), 64'(1));

    // T4: opcode trigger at cycle 3, short pre-history
    base = n_pop;
    expect_range(0, 10);
    do_arm(TRIG_OPC, 16'h123A);
    capture(10, -1);
    wait_drain("t4_drain");
    check("t4_count", 64'(n_pop - base), 64'(11));
    check("t4_wrapped", 64'(wrapped), 64'(0));

    // T5: external trigger and consumer backpressure
    base = n_pop;
    expect_range(0, 9);
    do_arm(TRIG_EXT, 16'h0005);
    capture(9, 2);
    wait_reads("t5_reach", base, 2);
    rd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t5_hold_valid", 64'(rd_valid), 64'(1));
    end
    rd_ready = 1'b1;
    wait_drain("t5_drain");
    check("t5_count", 64'(n_pop - base), 64'(10));

    // T6: re-arm in DRAIN while an entry is presented
    base = n_pop;
    expect_range(0, 7);
    do_arm(TRIG_IMM, 16'h0);
    capture(7, -1);
    wait_reads("t6_reach", base, 3);
    check("t6_reads", 64'(n_pop - base), 64'(3));
    rd_ready = 1'b0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    rd_ready = 1'b1;
    exp_q.delete();
    check("t6_rd_valid", 64'(rd_valid), 64'(0));
    check("t6_triggered", 64'(triggered), 64'(0));
    check("t6_busy", 64'(busy), 64'(1));
    base = n_pop;
    expect_range(0, 7);
    capture(7, -1);
    wait_drain("t6_drain");
    check("t6_count", 64'(n_pop - base), 64'(8));
    check("t6_triggered_end", 64'(triggered), 64'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
